// File: rtl/lvds_delay_calib.sv
// lvds_delay_calib: sweeps all delay taps against a training word and loads the centre of the widest passing window.
// Define DCALIB_TOGGLE_PATTERN_EN to also accept ~PATTERN (ADC toggle test mode).
module lvds_delay_calib #(
    parameter int          TAP_W      = 9,
    parameter int          NUM_TAPS   = 512,
    parameter int          SETTLE_CYC = 16,
    parameter int          CHECK_CYC  = 256,
    parameter int          MIN_EYE    = 8,
    parameter logic [11:0] PATTERN    = 12'hA5C
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [11:0]      data_in,
    output logic [TAP_W-1:0] delay_tap,
    output logic             delay_ld,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W:0]   eye_width
);
    localparam int CW = $clog2(SETTLE_CYC + CHECK_CYC + 1);
    localparam logic [CW-1:0] S_END = CW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
    localparam logic [CW-1:0] C_END = CW'(CHECK_CYC - 1);
    localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, EVAL, FINISH, APPLY} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [TAP_W-1:0] tap, run_start, best_start, res_tap, fin_start, res_n;
    logic [TAP_W:0] run_len, best_len, fin_len;
    logic bad, match, close_best, lock_n;

`ifdef DCALIB_TOGGLE_PATTERN_EN
    assign match = data_in == PATTERN || data_in == ~PATTERN;
`else
    assign match = data_in == PATTERN;
`endif

    // Closing the current run against the best is shared by EVAL and FINISH.
    assign close_best = run_len > best_len;
    assign fin_len    = close_best ? run_len : best_len;
    assign fin_start  = close_best ? run_start : best_start;
    assign res_n      = fin_start + TAP_W'(fin_len >> 1);
    assign lock_n     = fin_len >= (TAP_W + 1)'(MIN_EYE);

    assign busy      = state != IDLE;
    assign delay_ld  = state == LOAD || state == APPLY;
    assign done      = state == APPLY;
    assign delay_tap = (state == IDLE || state == APPLY) ? res_tap : tap;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = SETTLE;
            SETTLE:  state_n = cnt == S_END ? CHECK : SETTLE;
            CHECK:   state_n = cnt == C_END ? EVAL : CHECK;
            EVAL:    state_n = tap == LAST ? FINISH : LOAD;
            FINISH:  state_n = APPLY;
            APPLY:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tap        <= '0;
            bad        <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            res_tap    <= '0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            eye_width  <= '0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : cnt + 1'b1;
            if (state == IDLE && start) begin
                tap        <= '0;
                locked     <= 1'b0;
                fail       <= 1'b0;
                run_len    <= '0;
                run_start  <= '0;
                best_len   <= '0;
                best_start <= '0;
            end
            if (state == LOAD)
                bad <= 1'b0;
            if (state == CHECK && !match)
                bad <= 1'b1;
            if (state == EVAL) begin
                if (!bad) begin
                    run_len <= run_len + 1'b1;
                    if (run_len == '0)
                        run_start <= tap;
                end else begin
                    if (close_best) begin
                        best_len   <= run_len;
                        best_start <= run_start;
                    end
                    run_len <= '0;
                end
                if (tap != LAST)
                    tap <= tap + 1'b1;
            end
            if (state == FINISH) begin
                res_tap   <= lock_n ? res_n : '0;
                locked    <= lock_n;
                fail      <= !lock_n;
                eye_width <= fin_len;
            end
        end
    end
endmodule

// File: tb/tb_lvds_delay_calib.sv
// tb_lvds_delay_calib: randomized and directed tap sweeps scored against a window-search model.
module tb_lvds_delay_calib;
    localparam int NT = 16;
    localparam int S  = 2;
    localparam int C  = 4;
    localparam int ME = 3;
    localparam int TW = 4;
    localparam logic [11:0] PAT = 12'hA5C;

    typedef struct {
        int tap;
        int eye;
        bit lock;
    } exp_t;

    logic sys_clk, rst, start;
    logic [11:0] data_in;
    logic [TW-1:0] delay_tap;
    logic delay_ld, busy, done, locked, fail;
    logic [TW:0] eye_width;

    logic [11:0] samp [NT][C];
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    lvds_delay_calib #(
        .TAP_W(TW), .NUM_TAPS(NT), .SETTLE_CYC(S), .CHECK_CYC(C), .MIN_EYE(ME), .PATTERN(PAT)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .data_in(data_in),
        .delay_tap(delay_tap), .delay_ld(delay_ld), .busy(busy), .done(done),
        .locked(locked), .fail(fail), .eye_width(eye_width)
    );

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic bit pass(input logic [11:0] d);
`ifdef DCALIB_TOGGLE_PATTERN_EN
        return d == PAT || d == ~PAT;
`else
        return d == PAT;
`endif
    endfunction

    // Reference: every tap is good iff all its samples pass; best = first longest run of good taps.
    task automatic push_expect();
        bit good[NT];
        int bl, bs, len;
        exp_t e;
        for (int t = 0; t < NT; t++) begin
            good[t] = 1;
            for (int i = 0; i < C; i++)
                if (!pass(samp[t][i])) good[t] = 0;
        end
        bl = 0;
        bs = 0;
        for (int s = 0; s < NT; s++) begin
            len = 0;
            while (s + len < NT && good[s + len]) len++;
            if (len > bl) begin
                bl = len;
                bs = s;
            end
        end
        e.lock = bl >= ME;
        e.eye  = bl;
        e.tap  = e.lock ? bs + bl / 2 : 0;
        exp_q.push_back(e);
    endtask

    task automatic fill(input logic [NT-1:0] m);
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < C; i++)
                samp[t][i] = m[t] ? PAT : 12'h000;
    endtask

    task automatic fill_toggle();
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < C; i++)
                samp[t][i] = i % 2 == 0 ? PAT : 12'h5A3;
    endtask

    task automatic fill_random();
        int lo, len;
        logic [NT-1:0] m;
        lo  = $urandom_range(0, NT - 1);
        len = $urandom_range(0, NT - lo);
        m = NT'($urandom) & NT'($urandom);
        for (int t = lo; t < lo + len; t++) m[t] = 1'b1;
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < C; i++)
                samp[t][i] = m[t] ? PAT : 12'($urandom);
            if (m[t] && $urandom_range(0, 5) == 0)
                samp[t][$urandom_range(0, C - 1)] = 12'($urandom);
        end
    endtask

    // Drives the planned sample for the tap last loaded; garbage outside CHECK must be ignored.
    initial begin
        int k, ct;
        k = 1000;
        ct = 0;
        data_in = 12'h000;
        forever begin
            @(posedge sys_clk);
            #1;
            if (delay_ld && busy) begin
                ct = int'(delay_tap);
                k = 0;
            end else if (k < 1000) k++;
            data_in = (busy && k >= 1 + S && k < 1 + S + C) ? samp[ct][k - 1 - S] : 12'($urandom);
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin : monitor
        int n, nld;
        bit was_done;
        exp_t e;
        n = 0;
        nld = 0;
        was_done = 0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                chk("reset_outputs", int'({delay_tap, delay_ld, busy, done, locked, fail, eye_width}), 0);
                exp_q.delete();
                n = 0;
                nld = 0;
                was_done = 0;
            end else begin
                if (was_done) chk("idle_after_done", int'(busy), 0);
                was_done = done;
                if (!busy) begin
                    n = 0;
                    nld = 0;
                end else begin
                    n++;
                    if (delay_ld) begin
                        nld++;
                        if (!done) chk("sweep_tap", int'(delay_tap), nld - 1);
                    end
                    if (done) begin
                        chk("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("done_cycle", n, NT * (S + C + 2) + 2);
                            chk("ld_count", nld, NT + 1);
                            chk("final_ld", int'(delay_ld), 1);
                            chk("final_tap", int'(delay_tap), e.tap);
                            chk("eye_width", int'(eye_width), e.eye);
                            chk("locked", int'(locked), int'(e.lock));
                            chk("fail", int'(fail), int'(!e.lock));
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1;
        @(posedge sys_clk);
        #1 start = 0;
    endtask

    task automatic calibrate(input bit twice);
        push_expect();
        pulse_start();
        if (twice) begin
            repeat (20) @(posedge sys_clk);
            #1;
            pulse_start();
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge sys_clk);
            #1;
        end
        if (!done) begin
            $display("FAIL done_timeout got 0 expected 1");
            $fatal(1, "calibration did not complete");
        end
        pulse_start();
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        rst = 1;
        start = 0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 0;
        fill(16'h07E0);
        calibrate(0);
        fill(16'h1E1E);
        calibrate(0);
        fill(16'hF80C);
        calibrate(0);
        fill(16'h0000);
        calibrate(0);
        fill(16'h00C0);
        calibrate(0);
        fill(16'h07E0);
        samp[7][2] = 12'h000;
        calibrate(0);
        fill_toggle();
        calibrate(0);
        fill(16'h07E0);
        push_expect();
        pulse_start();
        repeat (49) @(posedge sys_clk);
        #2 rst = 1;
        repeat (2) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 rst = 0;
        @(negedge sys_clk);
        #1;
        calibrate(1);
        repeat (6) begin
            fill_random();
            calibrate(0);
        end
        repeat (3) @(posedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lvds_delay_calib.md
# lvds_delay_calib

Training-pattern delay calibration controller for one ADC LVDS capture bus. It sits beside the per-bit IDDRE1 capture of a channel and drives a shared input-delay tap value for that bus. It sweeps all taps, checks the synchronised 12-bit capture word against a known ADC training pattern, finds the widest contiguous passing window, and loads the tap at its centre. It reports lock or failure to the system controller.

## Interface
- `TAP_W`, 9: delay tap width (`NUM_TAPS` ≤ 2^`TAP_W`).
- `NUM_TAPS`, 512: number of taps swept, 0..`NUM_TAPS`-1.
- `SETTLE_CYC`, 16: cycles waited after each tap load before checking.
- `CHECK_CYC`, 256: consecutive samples compared per tap.
- `MIN_EYE`, 8: minimum window width (taps) for lock.
- `PATTERN`, 12'hA5C: expected training word.
- `sys_clk`  in  1  only clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; ignored while `busy`.
- `data_in`  in  12  capture word already synchronised to `sys_clk`, one sample per cycle.
- `delay_tap`  out  `TAP_W`  tap value to the delay elements.
- `delay_ld`  out  1  one-cycle load strobe; `delay_tap` is valid in the same cycle.
- `busy`  out  1  calibration in progress.
- `done`  out  1  one-cycle pulse at the end of calibration.
- `locked`  out  1  level: last calibration found a window ≥ `MIN_EYE`.
- `fail`  out  1  level: last calibration found no window ≥ `MIN_EYE`.
- `eye_width`  out  `TAP_W`+1  width of the best window from the last run.

## Operation
- States:
  - IDLE → LOAD on `start`, at tap 0. Entering LOAD also clears `locked`, `fail`, the run tracker and the best-window tracker.
  - LOAD: drive `delay_tap` = current tap and pulse `delay_ld`. Go to SETTLE.
  - SETTLE: count `SETTLE_CYC` cycles. Go to CHECK.
  - CHECK: compare `data_in` each cycle for `CHECK_CYC` cycles. Any mismatch marks the tap bad. Sampling continues for the full count. Go to EVAL.
  - EVAL: update the window trackers. If current tap = `NUM_TAPS`-1, go to FINISH. Otherwise increment the tap and go to LOAD.
  - FINISH: close any open run, then decide the result (see below). Go to APPLY.
  - APPLY: drive `delay_tap` = result tap and pulse `delay_ld`. Pulse `done` in the same cycle. Set `locked` or `fail`. Go to IDLE.
- Run tracking:
  - A good tap extends the current run; the run start is recorded at the first good tap.
  - A bad tap closes the current run.
  - A closed run replaces the best window only if strictly longer, so on a tie the lowest-start window wins.
  - A run still open at the last tap is closed in FINISH.
- Result:
  - If best length ≥ `MIN_EYE`: result tap = best_start + (best_len >> 1), truncated; `locked` = 1; `eye_width` = best_len.
  - Otherwise: result tap = 0, `fail` = 1, and `eye_width` = best_len (may be 0).
- `busy` is high in every state except IDLE.

## Timing
- Cycles per tap = 1 + `SETTLE_CYC` + `CHECK_CYC` + 1.
- Total time from the `start` edge to `done` = `NUM_TAPS` × (`SETTLE_CYC` + `CHECK_CYC` + 2) + 2 cycles (FINISH + APPLY). The `done` pulse falls in the APPLY cycle.
- The comparison uses `data_in` as registered on the CHECK cycle edges only. Samples taken in SETTLE are ignored.
- `start` asserted in the same cycle as `done` is ignored, because `busy` is still high.
- Reset values, on assertion and at any point including mid-sweep:
  - state = IDLE;
  - `delay_tap` = 0, `delay_ld` = 0, `busy` = 0, `done` = 0, `locked` = 0, `fail` = 0, `eye_width` = 0;
  - no load strobe is issued on the way out of reset.
- Counters are sized so that `SETTLE_CYC` = 0 or `CHECK_CYC` = 1 are legal. `SETTLE_CYC` = 0 means SETTLE lasts zero wait cycles but remains a single-cycle state.

## Configuration
- `DCALIB_TOGGLE_PATTERN_EN`:
  - Defined: a CHECK sample passes if `data_in` equals `PATTERN` or `~PATTERN`. This supports ADC toggle test mode with no phase tracking.
  - Not defined: only `PATTERN` passes.

## Test plan
All scenarios use bench parameters `NUM_TAPS`=16, `SETTLE_CYC`=2, `CHECK_CYC`=4, `MIN_EYE`=3, `PATTERN`=12'hA5C.
- Good taps 5–10, other taps drive 12'h000 → `delay_ld` pulses 17 times, final `delay_tap` = 8, `eye_width` = 6, `locked` = 1, `done` at cycle 16×8+2 = 130 after `start`.
- Windows 1–4 and 9–12 (tie) → final tap = 3, `eye_width` = 4. Windows 2–3 and 11–15 → tap = 13, `eye_width` = 5, with the open run closed at the end.
- All taps bad → `fail` = 1, `locked` = 0, final tap = 0, `eye_width` = 0. Window 6–7 only → `fail` = 1, `eye_width` = 2.
- Tap 7 of a 5–10 window has a single mismatch in its 3rd CHECK sample → tap 7 is bad, best window is 8–10, tap = 9, `locked` = 1.
- `rst` asserted at cycle 50 → all outputs 0 immediately. A later `start` restarts the sweep from tap 0, and the second `start` pulse sent while `busy` is ignored.
- Data alternates 12'hA5C/12'h5A3 on all taps → with `DCALIB_TOGGLE_PATTERN_EN` defined: `locked` = 1, `eye_width` = 16, tap = 8. Without it: `fail` = 1.
